// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier sequencer with HI/LO ownership for the MIPS Execute stage.
// Multiplies operand magnitudes one bit per cycle, then applies the sign in a single fix-up cycle.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multstartE,
  input  logic             multsignE,
  input  logic             aluormultE,
  input  logic             lohiE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stallE,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] multresultE
);

  // state | meaning
  // IDLE  | no product in flight; HI/LO readable without stall
  // RUN   | WIDTH shift-add iterations on the operand magnitudes
  // FIX   | negate if needed and write HI/LO

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fix;

  assign busy        = (state_q != IDLE);
  assign stallE      = busy & (multstartE | aluormultE);
  assign accept      = multstartE & ~stallE;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign multresultE = lohiE ? hi_q : lo_q;

  // The multiplier register doubles as the low half of the accumulator.
  assign sum      = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod     = {acc_hi_q, mplier_q};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = (multsignE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
          mplier_d = (multsignE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
          neg_d    = multsignE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_hi_d = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = prod_fix[WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
